// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified memory port arbiter.
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// Saturating counter of consecutive grants that bypassed a waiting requester.
module arb_starve_counter #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has precedence; increments stop once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// load/store, one transaction at a time, with back-to-back issue on ack.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              spurious_ack
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              spurious_q, spurious_d;

  logic       ack_evt, arb_en, i_elig, d_elig;
  logic [1:0] gnt;
  logic       starve_at_limit, starve_clr, starve_inc;

  assign ack_evt = mem_ack & mem_req_q;
  assign arb_en  = (state_q == IDLE) | ack_evt;

  // A requester whose transaction is completing, or whose ready pulse is
  // showing, still has req high for the finished access and must not win.
  assign i_elig = if_req & ~if_ready_q & ~(ack_evt & (state_q == SERVE_I));
  assign d_elig = d_req  & ~d_ready_q  & ~(ack_evt & (state_q == SERVE_D));

  always_comb begin
    gnt = GNT_NONE;
    if (arb_en) begin
      if (i_elig && (!d_elig || starve_at_limit)) begin
        gnt = GNT_I;
      end else if (d_elig) begin
        gnt = GNT_D;
      end
    end
  end

  assign starve_clr = (gnt == GNT_I) | ((gnt == GNT_D) & ~if_req);
  assign starve_inc = (gnt == GNT_D) & if_req;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (starve_clr),
    .inc_i      (starve_inc),
    .at_limit_o (starve_at_limit)
  );

  // Completion, capture and the next memory request are all decided in the
  // same cycle so a new grant follows an ack with no idle gap.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if_ready_d  = ack_evt & (state_q == SERVE_I);
    d_ready_d   = ack_evt & (state_q == SERVE_D);
    if_rdata_d  = if_ready_d ? mem_rdata : if_rdata_q;
    d_rdata_d   = d_ready_d ? (mem_we_q ? '0 : mem_rdata) : d_rdata_q;
    spurious_d  = spurious_q | (mem_ack & ~mem_req_q);

    case (gnt)
      GNT_I: begin
        state_d     = SERVE_I;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
      GNT_D: begin
        state_d     = SERVE_D;
        mem_req_d   = 1'b1;
        mem_we_d    = d_we;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end
      default: begin
        if (ack_evt) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      spurious_q  <= spurious_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_ready     = if_ready_q;
  assign if_rdata     = if_rdata_q;
  assign d_ready      = d_ready_q;
  assign d_rdata      = d_rdata_q;
  assign spurious_ack = spurious_q;

  // Stalls depend only on requester inputs and ready registers, never mem_ack.
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a variable-latency memory model.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        spurious_ack;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        txnQ[$];
  logic [31:0] ifQ[$];
  logic [31:0] dQ[$];

  int checks = 0;
  int errors = 0;
  int ifReadyCnt = 0;
  int dReadyCnt = 0;
  int memReqFalls = 0;
  bit prevMemReq = 0;

  int ackLatency = 1;
  bit modelOn = 1;
  bit injectAck = 0;

  unified_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .spurious_ack (spurious_ack)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0000: memRead = 32'h0050_0093;
      32'h0000_0008: memRead = 32'h00A0_0113;
      32'h0000_0100: memRead = 32'hCAFE_F00D;
      32'h0000_0020: memRead = 32'h0000_1234;
      default:       memRead = a + 32'h1000_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    txnQ.push_back(t);
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // Returns on the posedge that ends the cycle in which the target ready count was seen.
  task automatic waitReady(input bit isData, input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (((isData ? dReadyCnt : ifReadyCnt) < target) && (n < 200));
    if ((isData ? dReadyCnt : ifReadyCnt) < target)
      checkOutput(isData ? "d_ready_timeout" : "if_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks the ackLatency-th cycle of each request and checks the
  // request fields against the expected grant order.
  initial begin : memModel
    int   waitCnt;
    txn_t cur;
    txn_t exp;
    waitCnt   = 0;
    mem_ack   = 0;
    mem_rdata = 0;
    cur       = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      if (!modelOn) begin
        waitCnt = 0;
        mem_ack = injectAck;
      end else if (mem_req) begin
        waitCnt++;
        if (waitCnt == 1) begin
          cur.we = mem_we;
          cur.addr = mem_addr;
          cur.wdata = mem_wdata;
          if (txnQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_txn: got addr 0x%0h, expected no request", mem_addr);
          end else begin
            exp = txnQ.pop_front();
            checkOutput("txn_we", {63'd0, mem_we}, {63'd0, exp.we});
            checkOutput("txn_addr", {32'd0, mem_addr}, {32'd0, exp.addr});
            checkOutput("txn_wdata", {32'd0, mem_wdata}, {32'd0, exp.wdata});
          end
        end else begin
          checkOutput("txn_stable", {mem_we, mem_addr, mem_wdata}, cur);
        end
        if (waitCnt >= ackLatency) begin
          mem_ack   = 1;
          mem_rdata = memRead(mem_addr);
          waitCnt   = 0;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (if_ready) begin
        if (ifQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_if_ready: got 1, expected 0");
        end else begin
          checkOutput("if_rdata", {32'd0, if_rdata}, {32'd0, ifQ.pop_front()});
        end
        ifReadyCnt++;
      end
      if (d_ready) begin
        if (dQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_d_ready: got 1, expected 0");
        end else begin
          checkOutput("d_rdata", {32'd0, d_rdata}, {32'd0, dQ.pop_front()});
        end
        dReadyCnt++;
      end
      if (prevMemReq && !mem_req) memReqFalls++;
      prevMemReq = mem_req;
    end
  end

  initial begin : stimulus
    int base;
    reset = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_ready", {63'd0, if_ready}, 64'd0);
    checkOutput("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
    checkOutput("rst_d_ready", {63'd0, d_ready}, 64'd0);
    checkOutput("rst_d_rdata", {32'd0, d_rdata}, 64'd0);
    checkOutput("rst_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("rst_mem_we", {63'd0, mem_we}, 64'd0);
    checkOutput("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    checkOutput("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    checkOutput("rst_spurious", {63'd0, spurious_ack}, 64'd0);
    checkOutput("rst_stall_if", {63'd0, stall_if}, 64'd0);
    checkOutput("rst_stall_mem", {63'd0, stall_mem}, 64'd0);
    tick();
    reset = 0;
    tick();

    $display("[TB] single fetch");
    ackLatency = 3;
    pushTxn(0, 32'h0, 32'h0);
    ifQ.push_back(32'h0050_0093);
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    waitReady(0, 1);
    #1 if_req = 0;
    tick();

    $display("[TB] simultaneous requests");
    ackLatency = 1;
    base = memReqFalls;
    pushTxn(0, 32'h100, 32'h0);
    pushTxn(0, 32'h8, 32'h0);
    dQ.push_back(32'hCAFE_F00D);
    ifQ.push_back(32'h00A0_0113);
    applyStimulus(1, 32'h8, 1, 0, 32'h100, 0);
    waitReady(1, 1);
    #1 d_req = 0;
    waitReady(0, 2);
    #1 if_req = 0;
    @(negedge clk);
    checkOutput("no_gap_falls", 64'(memReqFalls - base), 64'd1);
    tick();

    $display("[TB] starvation limit");
    ackLatency = 2;
    for (int n = 0; n < 3; n++) begin
      pushTxn(0, 32'h300 + 32'(4 * n), 32'h0);
      dQ.push_back(32'h1000_0300 + 32'(4 * n));
      base = dReadyCnt;
      applyStimulus(1, 32'h200, 1, 0, 32'h300 + 32'(4 * n), 0);
      tick();
      if_req = 0;
      waitReady(1, base + 1);
      #1 d_req = 0;
      tick();
    end
    pushTxn(0, 32'h200, 32'h0);
    pushTxn(0, 32'h310, 32'h0);
    ifQ.push_back(32'h1000_0200);
    dQ.push_back(32'h1000_0310);
    base = dReadyCnt;
    applyStimulus(1, 32'h200, 1, 0, 32'h310, 0);
    waitReady(0, 3);
    #1 if_req = 0;
    waitReady(1, base + 1);
    #1 d_req = 0;
    tick();

    $display("[TB] store");
    ackLatency = 1;
    pushTxn(1, 32'h20, 32'hDEAD_BEEF);
    dQ.push_back(32'h0);
    base = dReadyCnt;
    applyStimulus(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
    waitReady(1, base + 1);
    #1 applyStimulus(0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] stall outputs");
    ackLatency = 2;
    pushTxn(0, 32'h44, 32'h0);
    dQ.push_back(32'h1000_0044);
    applyStimulus(0, 0, 1, 0, 32'h44, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("stall_mem", {63'd0, stall_mem}, (k < 3) ? 64'd1 : 64'd0);
      checkOutput("stall_if", {63'd0, stall_if}, 64'd0);
      tick();
    end
    d_req = 0;
    tick();
    @(negedge clk);
    checkOutput("idle_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("hold_if_rdata", {32'd0, if_rdata}, {32'd0, 32'h1000_0200});
    checkOutput("hold_d_rdata", {32'd0, d_rdata}, {32'd0, 32'h1000_0044});
    checkOutput("spurious_clean", {63'd0, spurious_ack}, 64'd0);

    $display("[TB] reset mid-transaction");
    modelOn = 0;
    tick();
    applyStimulus(1, 32'h40, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    checkOutput("pending_mem_req", {63'd0, mem_req}, 64'd1);
    tick();
    reset = 1;
    if_req = 0;
    tick();
    reset = 0;
    @(negedge clk);
    checkOutput("midrst_mem_req", {63'd0, mem_req}, 64'd0);
    checkOutput("midrst_mem_addr", {32'd0, mem_addr}, 64'd0);
    checkOutput("midrst_if_ready", {63'd0, if_ready}, 64'd0);
    checkOutput("midrst_if_rdata", {32'd0, if_rdata}, 64'd0);
    checkOutput("midrst_d_rdata", {32'd0, d_rdata}, 64'd0);
    injectAck = 1;
    tick();
    @(negedge clk);
    checkOutput("spurious_before", {63'd0, spurious_ack}, 64'd0);
    injectAck = 0;
    tick();
    @(negedge clk);
    checkOutput("spurious_set", {63'd0, spurious_ack}, 64'd1);
    checkOutput("late_if_ready", {63'd0, if_ready}, 64'd0);
    checkOutput("late_mem_req", {63'd0, mem_req}, 64'd0);
    repeat (2) tick();
    @(negedge clk);
    checkOutput("spurious_sticky", {63'd0, spurious_ack}, 64'd1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    checkOutput("spurious_cleared", {63'd0, spurious_ack}, 64'd0);

    checkOutput("txnq_empty", 64'(txnQ.size()), 64'd0);
    checkOutput("ifq_empty", 64'(ifQ.size()), 64'd0);
    checkOutput("dq_empty", 64'(dQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
